// File: rtl/digest_pager.sv
// Captures a wide digest on the rising edge of its valid flag and pages through it one
// WIN_W-bit window at a time; define AUTO_SCROLL_EN to add timed auto-scroll.
module digest_pager #(
    parameter int DATA_W     = 1088,
    parameter int WIN_W      = 32,
    parameter int SCROLL_DIV = 50000000,
    localparam int PAGES     = (DATA_W + WIN_W - 1) / WIN_W,
    localparam int PG_W      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              data_valid_i,
    input  logic              freeze_i,
    input  logic              next_pg_i,
    input  logic              prev_pg_i,
    input  logic              auto_mode_i,
    output logic [WIN_W-1:0]  window_o,
    output logic [PG_W-1:0]   page_o,
    output logic              captured_o
);

    localparam int              PAD_W  = PAGES * WIN_W;
    localparam logic [PG_W-1:0] PG_TOP = PG_W'(PAGES - 1);

    logic [DATA_W-1:0] digest_q, digest_d;
    logic [PG_W-1:0]   page_q, page_d;
    logic [WIN_W-1:0]  window_q, window_d;
    logic              captured_q, captured_d;
    logic              dv_q, nx_q, pv_q;

    logic              cap, next_rise, prev_rise, auto_step, do_next;
    logic [PAD_W-1:0]  padded;

    assign cap       = data_valid_i & ~dv_q & ~freeze_i;
    assign next_rise = next_pg_i & ~nx_q;
    assign prev_rise = prev_pg_i & ~pv_q;

`ifdef AUTO_SCROLL_EN
    localparam int CNT_W = $clog2(SCROLL_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             manual, tc;

    assign manual    = next_rise | prev_rise;
    assign tc        = auto_mode_i & (cnt_q == CNT_W'(SCROLL_DIV - 1));
    // A manual press in the terminal-count cycle swallows the auto step.
    assign auto_step = tc & ~manual;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (manual || !auto_mode_i || tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_auto_mode;

    assign unused_auto_mode = auto_mode_i;
    assign auto_step        = 1'b0;
`endif

    assign do_next = (next_rise & ~prev_rise) | auto_step;

    always_comb begin
        digest_d   = cap ? data_in_i : digest_q;
        captured_d = captured_q | cap;
        page_d     = page_q;
        if (do_next) begin
            page_d = (page_q == '0) ? PG_TOP : page_q - PG_W'(1);
        end else if (prev_rise && !next_rise) begin
            page_d = (page_q == PG_TOP) ? '0 : page_q + PG_W'(1);
        end
        // Zero extension pads the top page above DATA_W.
        padded   = PAD_W'(digest_d);
        window_d = WIN_W'(padded >> (32'(page_d) * WIN_W));
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            digest_q   <= '0;
            page_q     <= PG_TOP;
            window_q   <= '0;
            captured_q <= 1'b0;
            dv_q       <= 1'b0;
            nx_q       <= 1'b0;
            pv_q       <= 1'b0;
        end else begin
            digest_q   <= digest_d;
            page_q     <= page_d;
            window_q   <= window_d;
            captured_q <= captured_d;
            dv_q       <= data_valid_i;
            nx_q       <= next_pg_i;
            pv_q       <= prev_pg_i;
        end
    end

    assign window_o   = window_q;
    assign page_o     = page_q;
    assign captured_o = captured_q;

endmodule

// File: tb/tb_digest_pager.sv
// Directed and randomized checks of digest_pager against a page-level reference model
// (DATA_W=40, WIN_W=16, SCROLL_DIV=4 -> 3 pages); honours AUTO_SCROLL_EN.
module tb_digest_pager;

    localparam int DATA_W     = 40;
    localparam int WIN_W      = 16;
    localparam int SCROLL_DIV = 4;
    localparam int PAGES      = 3;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic [39:0] data_in;
    logic        dv, frz, nx, pv, auto_mode;
    logic [15:0] window;
    logic [1:0]  page;
    logic        captured;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [39:0] m_digest;
    int          m_page;
    bit          m_cap;
    bit          m_dv, m_nx, m_pv;
    int          m_cnt;

    digest_pager #(
        .DATA_W    (DATA_W),
        .WIN_W     (WIN_W),
        .SCROLL_DIV(SCROLL_DIV)
    ) dut (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .data_in_i   (data_in),
        .data_valid_i(dv),
        .freeze_i    (frz),
        .next_pg_i   (nx),
        .prev_pg_i   (pv),
        .auto_mode_i (auto_mode),
        .window_o    (window),
        .page_o      (page),
        .captured_o  (captured)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_win();
        logic [47:0] d;
        d = {8'h00, m_digest};
        return 16'(d >> (m_page * WIN_W));
    endfunction

    task automatic model_reset();
        m_digest = '0;
        m_page   = PAGES - 1;
        m_cap    = 1'b0;
        m_dv     = 1'b0;
        m_nx     = 1'b0;
        m_pv     = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic model_clock();
        bit c, nr, pr, auto_next;
        c         = dv && !m_dv && !frz;
        nr        = nx && !m_nx;
        pr        = pv && !m_pv;
        auto_next = 1'b0;
`ifdef AUTO_SCROLL_EN
        if (nr || pr || !auto_mode) m_cnt = 0;
        else if (m_cnt == SCROLL_DIV - 1) begin
            m_cnt     = 0;
            auto_next = 1'b1;
        end else m_cnt++;
`endif
        if (c) begin
            m_digest = data_in;
            m_cap    = 1'b1;
        end
        if ((nr && !pr) || auto_next) m_page = (m_page + PAGES - 1) % PAGES;
        else if (pr && !nr)           m_page = (m_page + 1) % PAGES;
        m_dv = dv;
        m_nx = nx;
        m_pv = pv;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_win"},  48'(window),   48'(m_win()));
        chk({tag, "_page"}, 48'(page),     48'(m_page));
        chk({tag, "_cap"},  48'(captured), 48'(m_cap));
    endtask

    task automatic step(input string tag);
        @(posedge clock_i);
        model_clock();
        @(negedge clock_i);
        check_all(tag);
    endtask

    initial begin
        reset_n_i = 1'b0;
        data_in   = '0;
        dv = 0; frz = 0; nx = 0; pv = 0; auto_mode = 0;
        model_reset();
        repeat (2) @(negedge clock_i);
        check_all("rst");
        chk("rst_win_c", 48'(window), 48'h0);
        chk("rst_page_c", 48'(page), 48'd2);
        reset_n_i = 1'b1;
        step("idle");

        // 1: capture
        data_in = 40'hA1_B2C3_D4E5;
        dv = 1;
        step("t1");
        chk("t1_win_c", 48'(window), 48'h00A1);
        chk("t1_cap_c", 48'(captured), 48'd1);
        dv = 0;
        step("t1b");

        // 2: next stepping and wrap
        nx = 1; step("t2a"); chk("t2a_win_c", 48'(window), 48'hB2C3);
        nx = 0; step("t2a0");
        nx = 1; step("t2b"); chk("t2b_win_c", 48'(window), 48'hD4E5);
        nx = 0; step("t2b0");
        nx = 1; step("t2c"); chk("t2c_win_c", 48'(window), 48'h00A1);
        nx = 0; step("t2c0");

        // 3: prev wrap, simultaneous edges, held level
        pv = 1; step("t3a"); chk("t3a_page_c", 48'(page), 48'd0);
        pv = 0; step("t3a0");
        nx = 1; pv = 1; step("t3b"); chk("t3b_page_c", 48'(page), 48'd0);
        nx = 0; pv = 0; step("t3b0");
        nx = 1;
        for (int i = 0; i < 10; i++) step("t3c");
        chk("t3c_page_c", 48'(page), 48'd2);
        nx = 0; step("t3c0");

        // 4: freeze
        frz = 1; data_in = 40'hFF_FFFF_FFFF; dv = 1;
        step("t4a"); chk("t4a_win_c", 48'(window), 48'h00A1);
        dv = 0; step("t4b");
        frz = 0; step("t4c"); chk("t4c_win_c", 48'(window), 48'h00A1);

        // 5: async reset mid-operation
        data_in = 40'h12_3456_789A; dv = 1;
        step("t5a"); chk("t5a_win_c", 48'(window), 48'h0012);
        #2 reset_n_i = 1'b0;
        #1;
        model_reset();
        chk("t5_win_c", 48'(window), 48'h0);
        chk("t5_page_c", 48'(page), 48'd2);
        chk("t5_cap_c", 48'(captured), 48'd0);
        @(negedge clock_i);
        dv = 0; data_in = '0;
        reset_n_i = 1'b1;
        step("t5b");

`ifdef AUTO_SCROLL_EN
        // 6: auto scroll with manual override
        data_in = 40'h5A_1234_ABCD; dv = 1; step("t6cap");
        dv = 0; auto_mode = 1;
        for (int i = 0; i < 4; i++) step("t6a");
        chk("t6a_page_c", 48'(page), 48'd1);
        for (int i = 0; i < 2; i++) step("t6b");
        pv = 1; step("t6c"); chk("t6c_page_c", 48'(page), 48'd2);
        pv = 0;
        for (int i = 0; i < 3; i++) step("t6d");
        chk("t6d_page_c", 48'(page), 48'd2);
        step("t6e"); chk("t6e_page_c", 48'(page), 48'd1);
        for (int i = 0; i < 4; i++) step("t6f");
        chk("t6f_page_c", 48'(page), 48'd0);
        auto_mode = 0; step("t6g");
`endif

        // randomized phase
        for (int i = 0; i < 400; i++) begin
            data_in   = {8'($urandom), 32'($urandom)};
            dv        = ($urandom_range(3, 0) == 0);
            nx        = ($urandom_range(2, 0) == 0);
            pv        = ($urandom_range(3, 0) == 0);
            frz       = ($urandom_range(4, 0) == 0);
            auto_mode = ($urandom_range(9, 0) != 0);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
